// File: rtl/cube_pkg.sv
// Shared definitions for the LED cube voxel scanner.
// Contents: cube geometry constants, the scanner state enum and the
// {z,y,x} voxel index packing helper. No ports.
package cube_pkg;
    localparam int CUBE_DIM = 8;
    localparam int COORD_W  = $clog2(CUBE_DIM);
    localparam int OUT_W    = COORD_W + 1;
    localparam int COLOR_W  = 3;
    localparam int VOXELS   = CUBE_DIM * CUBE_DIM * CUBE_DIM;
    localparam int IDX_W    = 3 * COORD_W;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        SHOW,
        BLANK
    } scan_state_e;

    // x occupies the LSBs so a linear index walk is z,y,x order.
    function automatic logic [IDX_W-1:0] voxel_idx(input logic [COORD_W-1:0] x,
                                                   input logic [COORD_W-1:0] y,
                                                   input logic [COORD_W-1:0] z);
        return {z, y, x};
    endfunction
endpackage

// File: rtl/voxel_scan_sequencer_if.sv
// Bus bundle between the cube logic / display driver side and the scanner.
// master: drives scan_en, the voxel write port, clear_req and swap_req;
//         receives clear_busy, swap_ack, the voxel output strobe and frame_done.
// slave:  the scanner side of the same signals.
interface voxel_scan_sequencer_if;
    import cube_pkg::*;

    logic               scan_en;
    logic               wr_en;
    logic [COORD_W-1:0] wr_x;
    logic [COORD_W-1:0] wr_y;
    logic [COORD_W-1:0] wr_z;
    logic [COLOR_W-1:0] wr_color;
    logic               clear_req;
    logic               clear_busy;
    logic               swap_req;
    logic               swap_ack;
    logic               out_valid;
    logic [OUT_W-1:0]   out_x;
    logic [OUT_W-1:0]   out_y;
    logic [OUT_W-1:0]   out_z;
    logic [OUT_W-1:0]   out_color;
    logic               frame_done;

    modport master (
        output scan_en, wr_en, wr_x, wr_y, wr_z, wr_color, clear_req, swap_req,
        input  clear_busy, swap_ack, out_valid, out_x, out_y, out_z, out_color, frame_done
    );

    modport slave (
        input  scan_en, wr_en, wr_x, wr_y, wr_z, wr_color, clear_req, swap_req,
        output clear_busy, swap_ack, out_valid, out_x, out_y, out_z, out_color, frame_done
    );
endinterface

// File: rtl/voxel_frame_store.sv
// Double-buffered 512x3 voxel colour store.
// Ports: clk/resetn; swap toggles the front bank at the clock edge;
// wr_en/wr_idx/wr_color write the back bank; clear_req starts a 512-cycle
// zeroing sweep of the back bank (clear_busy high meanwhile, writes ignored);
// rd_idx is the index the scanner will use next cycle, rd_color its
// registered colour from the front bank.
module voxel_frame_store
    import cube_pkg::*;
(
    input  logic               clk,
    input  logic               resetn,
    input  logic               swap,
    input  logic               wr_en,
    input  logic [IDX_W-1:0]   wr_idx,
    input  logic [COLOR_W-1:0] wr_color,
    input  logic               clear_req,
    output logic               clear_busy,
    input  logic [IDX_W-1:0]   rd_idx,
    output logic [COLOR_W-1:0] rd_color
);
    logic [COLOR_W-1:0] bank0 [VOXELS];
    logic [COLOR_W-1:0] bank1 [VOXELS];

    logic               front_q, front_d;
    logic               clear_busy_q, clear_busy_d;
    logic [IDX_W-1:0]   clr_idx_q, clr_idx_d;
    logic               we;
    logic [IDX_W-1:0]   waddr;
    logic [COLOR_W-1:0] wdata;
    logic [COLOR_W-1:0] rd_color_q;

    always_comb begin
        front_d      = front_q ^ swap;
        clear_busy_d = clear_busy_q;
        clr_idx_d    = clr_idx_q;
        we           = 1'b0;
        waddr        = wr_idx;
        wdata        = wr_color;
        if (clear_busy_q) begin
            // The sweep owns the write port; user writes and new clears are dropped.
            we        = 1'b1;
            waddr     = clr_idx_q;
            wdata     = '0;
            clr_idx_d = clr_idx_q + 1'b1;
            if (clr_idx_q == IDX_W'(VOXELS - 1)) begin
                clear_busy_d = 1'b0;
            end
        end else begin
            we = wr_en;
            if (clear_req) begin
                clear_busy_d = 1'b1;
                clr_idx_d    = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            front_q      <= 1'b0;
            clear_busy_q <= 1'b0;
            clr_idx_q    <= '0;
        end else begin
            front_q      <= front_d;
            clear_busy_q <= clear_busy_d;
            clr_idx_q    <= clr_idx_d;
        end
    end

    // Writes target the pre-swap back bank, so a write coincident with a
    // swap ends up in the new front.
    always_ff @(posedge clk) begin
        if (we && front_q) begin
            bank0[waddr] <= wdata;
        end
        if (we && !front_q) begin
            bank1[waddr] <= wdata;
        end
    end

    // Read uses the post-swap front so the first FETCH of a frame sees the new bank.
    always_ff @(posedge clk) begin
        rd_color_q <= front_d ? bank1[rd_idx] : bank0[rd_idx];
    end

    assign clear_busy = clear_busy_q;
    assign rd_color   = rd_color_q;
endmodule

// File: rtl/voxel_scan_sequencer.sv
// LED cube scanner: walks the front buffer in z,y,x order and presents each
// lit voxel on out_x/y/z/color with out_valid for DWELL_CYCLES, then blanks
// for BLANK_CYCLES. Frame ends pulse frame_done and may swap the buffers.
// Ports: clk, resetn (sync, active-low), bus (slave side of
// voxel_scan_sequencer_if: scan control, write/clear/swap, voxel output).
module voxel_scan_sequencer
    import cube_pkg::*;
#(
    parameter int DWELL_CYCLES = 64,
    parameter int BLANK_CYCLES = 4,
    parameter bit SKIP_OFF     = 1'b1
) (
    input  logic                   clk,
    input  logic                   resetn,
    voxel_scan_sequencer_if.slave  bus
);
    localparam int CNT_W = 16;

    scan_state_e        state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               out_valid_q, out_valid_d;
    logic [COORD_W-1:0] out_x_q, out_x_d;
    logic [COORD_W-1:0] out_y_q, out_y_d;
    logic [COORD_W-1:0] out_z_q, out_z_d;
    logic [COLOR_W-1:0] out_color_q, out_color_d;
    logic               frame_done_q, frame_done_d;
    logic               swap_ack_q, swap_ack_d;
    logic               idx_inc;
    logic               swap_now;
    logic               clear_busy;
    logic [COLOR_W-1:0] rd_color;

    voxel_frame_store u_store (
        .clk        (clk),
        .resetn     (resetn),
        .swap       (swap_now),
        .wr_en      (bus.wr_en),
        .wr_idx     (voxel_idx(bus.wr_x, bus.wr_y, bus.wr_z)),
        .wr_color   (bus.wr_color),
        .clear_req  (bus.clear_req),
        .clear_busy (clear_busy),
        .rd_idx     (idx_d),
        .rd_color   (rd_color)
    );

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        out_valid_d  = out_valid_q;
        out_x_d      = out_x_q;
        out_y_d      = out_y_q;
        out_z_d      = out_z_q;
        out_color_d  = out_color_q;
        frame_done_d = 1'b0;
        swap_ack_d   = 1'b0;
        swap_now     = 1'b0;
        idx_inc      = 1'b0;
        if (!bus.scan_en) begin
            state_d     = IDLE;
            idx_d       = '0;
            cnt_d       = '0;
            out_valid_d = 1'b0;
            out_color_d = '0;
        end else begin
            unique case (state_q)
                IDLE: state_d = FETCH;
                FETCH: begin
                    if (SKIP_OFF && (rd_color == '0)) begin
                        idx_inc = 1'b1;
                    end else begin
                        out_x_d     = idx_q[COORD_W-1:0];
                        out_y_d     = idx_q[2*COORD_W-1:COORD_W];
                        out_z_d     = idx_q[3*COORD_W-1:2*COORD_W];
                        out_color_d = rd_color;
                        out_valid_d = 1'b1;
                        cnt_d       = '0;
                        state_d     = SHOW;
                    end
                end
                SHOW: begin
                    if (cnt_q == CNT_W'(DWELL_CYCLES - 1)) begin
                        out_valid_d = 1'b0;
                        out_color_d = '0;
                        cnt_d       = '0;
                        state_d     = BLANK;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                BLANK: begin
                    if (cnt_q == CNT_W'(BLANK_CYCLES - 1)) begin
                        idx_inc = 1'b1;
                        state_d = FETCH;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
            if (idx_inc) begin
                idx_d = idx_q + 1'b1;
                // Frame boundary: the only point at which the banks may swap.
                if (idx_q == IDX_W'(VOXELS - 1)) begin
                    frame_done_d = 1'b1;
                    swap_now     = bus.swap_req && !clear_busy;
                    swap_ack_d   = swap_now;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            out_valid_q  <= 1'b0;
            out_x_q      <= '0;
            out_y_q      <= '0;
            out_z_q      <= '0;
            out_color_q  <= '0;
            frame_done_q <= 1'b0;
            swap_ack_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            out_valid_q  <= out_valid_d;
            out_x_q      <= out_x_d;
            out_y_q      <= out_y_d;
            out_z_q      <= out_z_d;
            out_color_q  <= out_color_d;
            frame_done_q <= frame_done_d;
            swap_ack_q   <= swap_ack_d;
        end
    end

    assign bus.clear_busy = clear_busy;
    assign bus.swap_ack   = swap_ack_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_x      = {1'b0, out_x_q};
    assign bus.out_y      = {1'b0, out_y_q};
    assign bus.out_z      = {1'b0, out_z_q};
    assign bus.out_color  = {1'b0, out_color_q};
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_voxel_scan_sequencer.sv
// Directed bench for voxel_scan_sequencer (DWELL=64, BLANK=4, SKIP_OFF=1).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_voxel_scan_sequencer;
    import cube_pkg::*;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    voxel_scan_sequencer_if bus ();

    voxel_scan_sequencer #(
        .DWELL_CYCLES (64),
        .BLANK_CYCLES (4),
        .SKIP_OFF     (1'b1)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    localparam int S_VALID = 0;
    localparam int S_FDONE = 1;
    localparam int S_BUSY  = 2;
    localparam int S_ACK   = 3;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            S_VALID: return bus.out_valid;
            S_FDONE: return bus.frame_done;
            S_BUSY:  return bus.clear_busy;
            default: return bus.swap_ack;
        endcase
    endfunction

    task automatic wait_sig(input string tag, input int sel, input logic lvl,
                            input int budget, output int n);
        n = 0;
        while (sig(sel) !== lvl && n < budget) begin
            step();
            n++;
        end
        chk(tag, {31'b0, sig(sel)}, {31'b0, lvl});
    endtask

    task automatic write_voxel(input logic [2:0] x, input logic [2:0] y,
                               input logic [2:0] z, input logic [2:0] c);
        bus.wr_en = 1'b1; bus.wr_x = x; bus.wr_y = y; bus.wr_z = z; bus.wr_color = c;
        step();
        bus.wr_en = 1'b0;
    endtask

    // Expects a rise after exactly lat cycles, checks the shown voxel, its
    // dwell and the blanking gap; returns at the last blanking cycle.
    task automatic show_voxel(input string tag, input logic [3:0] ex, input logic [3:0] ey,
                              input logic [3:0] ez, input logic [3:0] ec, input int lat);
        int n;
        int bad;
        wait_sig({tag, " rise"}, S_VALID, 1'b1, lat + 50, n);
        chk({tag, " latency"}, n, lat);
        chk({tag, " out_x"}, bus.out_x, ex);
        chk({tag, " out_y"}, bus.out_y, ey);
        chk({tag, " out_z"}, bus.out_z, ez);
        chk({tag, " out_color"}, bus.out_color, ec);
        n = 0;
        bad = 0;
        while (bus.out_valid && n < 200) begin
            if (bus.out_x != ex || bus.out_y != ey || bus.out_z != ez || bus.out_color != ec)
                bad++;
            step();
            n++;
        end
        chk({tag, " dwell"}, n, 64);
        chk({tag, " stable"}, bad, 0);
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step();
            if (bus.out_valid || bus.out_color != 4'd0 || bus.out_x != ex ||
                bus.out_y != ey || bus.out_z != ez)
                bad++;
        end
        chk({tag, " blank"}, bad, 0);
    endtask

    initial begin
        int n;
        int lit;
        int busy_n;
        int acks_busy;
        int t0;

        resetn = 1'b0;
        bus.scan_en = 1'b0; bus.wr_en = 1'b0; bus.wr_x = '0; bus.wr_y = '0; bus.wr_z = '0;
        bus.wr_color = '0; bus.clear_req = 1'b0; bus.swap_req = 1'b0;
        repeat (3) step();
        chk("reset out_valid", bus.out_valid, 0);
        chk("reset out_x", bus.out_x, 0);
        chk("reset out_y", bus.out_y, 0);
        chk("reset out_z", bus.out_z, 0);
        chk("reset out_color", bus.out_color, 0);
        chk("reset frame_done", bus.frame_done, 0);
        chk("reset swap_ack", bus.swap_ack, 0);
        chk("reset clear_busy", bus.clear_busy, 0);
        resetn = 1'b1;
        step();

        // Clear the back bank while scanning; swap requested 10 cycles in.
        bus.scan_en = 1'b1;
        repeat (4) step();
        bus.clear_req = 1'b1;
        step();
        bus.clear_req = 1'b0;
        chk("clear_busy rise", bus.clear_busy, 1);
        busy_n = 0;
        acks_busy = 0;
        for (int i = 0; i < 600 && bus.clear_busy; i++) begin
            busy_n++;
            if (bus.swap_ack) acks_busy++;
            if (i == 9) bus.swap_req = 1'b1;
            if (i == 20) begin
                bus.wr_en = 1'b1; bus.wr_x = 3'd4; bus.wr_y = 3'd4; bus.wr_z = 3'd4;
                bus.wr_color = 3'd7;
            end else begin
                bus.wr_en = 1'b0;
            end
            step();
        end
        bus.wr_en = 1'b0;
        chk("clear_busy length", busy_n, 512);
        chk("no swap while clearing", acks_busy, 0);
        wait_sig("frame end after clear", S_FDONE, 1'b1, 40000, n);
        chk("deferred swap_ack", bus.swap_ack, 1);
        bus.swap_req = 1'b0;

        // New front is all zero: dark frames last 512 cycles.
        for (int f = 0; f < 2; f++) begin
            step();
            n = 1;
            lit = 0;
            while (!bus.frame_done && n < 2000) begin
                if (bus.out_valid) lit++;
                step();
                n++;
            end
            chk("dark frame period", n, 512);
            chk("dark frame out_valid", lit, 0);
        end

        // Zero the other bank too.
        bus.clear_req = 1'b1;
        step();
        bus.clear_req = 1'b0;
        wait_sig("second clear done", S_BUSY, 1'b0, 600, n);

        // Single voxel (1,2,3) colour 5 -> idx 209.
        write_voxel(3'd1, 3'd2, 3'd3, 3'd5);
        bus.swap_req = 1'b1;
        wait_sig("swap A frame end", S_FDONE, 1'b1, 1100, n);
        chk("swap A ack", bus.swap_ack, 1);
        bus.swap_req = 1'b0;
        show_voxel("voxA", 4'd1, 4'd2, 4'd3, 4'd5, 210);

        // Voxels at idx 0 and 511.
        write_voxel(3'd0, 3'd0, 3'd0, 3'd2);
        write_voxel(3'd7, 3'd7, 3'd7, 3'd6);
        bus.swap_req = 1'b1;
        wait_sig("swap B frame end", S_FDONE, 1'b1, 1100, n);
        chk("swap B ack", bus.swap_ack, 1);
        bus.swap_req = 1'b0;
        t0 = cyc;
        show_voxel("vox0", 4'd0, 4'd0, 4'd0, 4'd2, 1);
        show_voxel("vox511", 4'd7, 4'd7, 4'd7, 4'd6, 512);

        // Last blanking cycle of 511 is the wrap cycle: write and swap together.
        bus.wr_en = 1'b1; bus.wr_x = 3'd5; bus.wr_y = 3'd0; bus.wr_z = 3'd0; bus.wr_color = 3'd3;
        bus.swap_req = 1'b1;
        step();
        bus.wr_en = 1'b0;
        bus.swap_req = 1'b0;
        chk("frame_done after 511 blank", bus.frame_done, 1);
        chk("swap C ack", bus.swap_ack, 1);
        chk("two-voxel frame period", cyc - t0, 648);
        step();
        chk("frame_done one cycle", bus.frame_done, 0);
        chk("swap_ack one cycle", bus.swap_ack, 0);
        show_voxel("same-cycle write", 4'd5, 4'd0, 4'd0, 4'd3, 5);

        // Drop scan_en mid-SHOW of idx 209, then restart from idx 0.
        wait_sig("voxA again rise", S_VALID, 1'b1, 300, n);
        repeat (10) step();
        bus.scan_en = 1'b0;
        step();
        chk("out_valid after scan_en drop", bus.out_valid, 0);
        bus.scan_en = 1'b1;
        wait_sig("restart rise", S_VALID, 1'b1, 300, n);
        chk("restart latency", n, 7);
        chk("restart out_x", bus.out_x, 5);

        // Reset in the middle of a clear sweep.
        bus.clear_req = 1'b1;
        step();
        bus.clear_req = 1'b0;
        repeat (100) step();
        chk("clear running before reset", bus.clear_busy, 1);
        resetn = 1'b0;
        bus.scan_en = 1'b0;
        step();
        resetn = 1'b1;
        repeat (3) step();
        chk("post-reset clear_busy", bus.clear_busy, 0);
        chk("post-reset out_valid", bus.out_valid, 0);
        chk("post-reset out_x", bus.out_x, 0);
        chk("post-reset out_y", bus.out_y, 0);
        chk("post-reset out_z", bus.out_z, 0);
        chk("post-reset out_color", bus.out_color, 0);
        chk("post-reset frame_done", bus.frame_done, 0);
        chk("post-reset swap_ack", bus.swap_ack, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/voxel_scan_sequencer.md
Name: voxel_scan_sequencer

Overview:
Feeds the 8x8x8 LED cube display driver, one voxel per time slot. It holds a double-buffered voxel frame store: game/animation logic writes the back buffer while the scanner reads the front buffer. It walks the front buffer in z,y,x order and presents each lit voxel's coordinate and colour with an enable strobe for a fixed dwell time, followed by a blanking gap. Buffers swap only on frame boundaries, under a request/acknowledge handshake.

Parameters:
DWELL_CYCLES, 64, cycles out_valid is held high per lit voxel (>=1)
BLANK_CYCLES, 4, cycles out_valid is low between two shown voxels (>=1)
SKIP_OFF, 1, 1 = voxels with colour 0 consume one FETCH cycle and are never shown; 0 = shown like any other voxel

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
scan_en  in  1  1 = scanning runs; 0 = scanner returns to IDLE
wr_en  in  1  write one voxel into back buffer
wr_x  in  3  write x coordinate
wr_y  in  3  write y coordinate
wr_z  in  3  write z coordinate
wr_color  in  3  write colour, 0 = off
clear_req  in  1  pulse: zero entire back buffer
clear_busy  out  1  high while clear sweep runs
swap_req  in  1  level: request front/back swap at next frame end
swap_ack  out  1  one-cycle pulse when swap performed
out_valid  out  1  enable to display driver
out_x  out  4  voxel x, bit 3 always 0
out_y  out  4  voxel y, bit 3 always 0
out_z  out  4  voxel z, bit 3 always 0
out_color  out  4  voxel colour, bit 3 always 0
frame_done  out  1  one-cycle pulse when index wraps 511->0

Behaviour:
- Interface: reset resetn, synchronous, active-low; clock clk.
- Reset: state IDLE, idx=0, front=buffer 0, all outputs 0, clear counter idle. Buffer contents are not reset. Reset mid-frame or mid-clear aborts the operation immediately.
- idx is 9 bits, {z,y,x}, with x as the LSBs. Increment wraps 511->0.
- State machine states: IDLE, FETCH, SHOW, BLANK.
- IDLE: out_valid=0. If scan_en is sampled 1, go to FETCH.
- FETCH: takes 1 cycle with a registered read of front[idx].
  - If the colour is 0 and SKIP_OFF=1: increment idx and stay in FETCH.
  - Otherwise: register out_x/y/z/color and go to SHOW.
- First out_valid rises 2 cycles after scan_en is first sampled high.
- SHOW: out_valid=1 for exactly DWELL_CYCLES cycles. Outputs are stable throughout. Then go to BLANK.
- BLANK: out_valid=0 and out_color=0 for BLANK_CYCLES cycles. Coordinates hold. Then increment idx and go to FETCH.
- Frame end: on any idx increment 511->0, pulse frame_done.
  - In the same cycle, if swap_req=1 and clear_busy=0: toggle front and pulse swap_ack.
  - The new front is used by the next FETCH.
- An all-dark frame with SKIP_OFF=1 takes exactly 512 cycles.
- scan_en=0 in any state: next state IDLE, out_valid=0 on the next cycle, idx=0. No frame_done or swap occurs.
- Writes: when wr_en=1 and clear_busy=0, the write goes to back[{wr_z,wr_y,wr_x}] at the clock edge.
  - A write in the same cycle as a swap lands in the pre-swap back buffer, so it is visible in the new front.
  - A write to a location while scanning never affects the front buffer.
- Clear: clear_req while not busy starts a 512-cycle sweep that zeroes the back buffer. clear_busy is high for those 512 cycles, starting the cycle after clear_req.
  - wr_en is ignored while busy.
  - clear_req while busy is ignored.
  - A swap requested during a clear is deferred to the first frame end after clear_busy falls.
- swap_req is a level. The requester deasserts it after swap_ack. If still high, another swap occurs at the next frame end.
- Storage: two 512x3 arrays (inferable as RAM), with one read port (scanner) and one write port (writer/clear).

Decomposition:
- Shared package cube_pkg holds:
  - CUBE_DIM=8, COORD_W=3, OUT_W=4, COLOR_W=3, VOXELS=512
  - the state enum {IDLE, FETCH, SHOW, BLANK}
  - an index packing function {z,y,x}
- One natural sub-module: voxel_frame_store. It holds the dual-bank RAM with front select, the write/clear port, and the registered read port. The sequencer FSM and counters stay in the top.

Test Plan:
- Reset, then write (1,2,3,colour 5); swap; scan_en=1 (SKIP_OFF=1, DWELL=64, BLANK=4) -> swap_ack at first frame end; then out_valid high for exactly 64 cycles with out_x=1, out_y=2, out_z=3, out_color=5; then low for 4 cycles.
- Empty frame, scan_en=1 -> out_valid never rises; frame_done pulses every 512 cycles.
- Lit voxels at idx 0 and 511 -> shown in order 0 then 511; frame_done coincides with the 511->0 increment after 511's BLANK.
- clear_req, then swap_req raised 10 cycles later -> clear_busy high 512 cycles; a wr_en during the clear has no effect; swap_ack occurs only at the first frame end after the clear; the new front is all zero.
- Write plus swap at the same frame-end cycle -> the written voxel appears in the very next frame.
- scan_en dropped mid-SHOW, then resetn=0 mid-clear -> out_valid=0 the next cycle with idx=0 on restart; after reset, clear_busy=0 and all outputs are 0.
